// File: rtl/wb_ram_slave_if.sv
// Wishbone bus bundle between the multi-CPU arbiter (master) and the shared data RAM (slave).
// wb_err exists only when WB_ERR_EN is defined.
interface wb_ram_slave_if #(
    parameter int DATA_W = 32
);
    logic              wb_cyc;
    logic              wb_stb;
    logic              wb_we;
    logic [DATA_W-1:0] wb_adr;
    logic [DATA_W-1:0] wb_dat_i;
    logic [DATA_W-1:0] wb_dat_o;
    logic              wb_ack;
`ifdef WB_ERR_EN
    logic              wb_err;

    modport master (
        output wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_i,
        input  wb_dat_o, wb_ack, wb_err
    );

    modport slave (
        input  wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_i,
        output wb_dat_o, wb_ack, wb_err
    );
`else
    modport master (
        output wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_i,
        input  wb_dat_o, wb_ack
    );

    modport slave (
        input  wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_i,
        output wb_dat_o, wb_ack
    );
`endif
endinterface

// File: rtl/wb_ram_slave.sv
// Wishbone responder for the shared data RAM: programmable wait states, one ack per grant.
// Optional macro WB_ERR_EN: out-of-range requests answer with wb_err instead of wb_ack.
//
// state | meaning
// IDLE  | waiting for cyc&stb; request fields are latched when it is seen
// WAIT  | counting wait states; a dropped request aborts the transfer
// ACK   | single-cycle acknowledge (RAM access happened on the entering edge)
// HOLD  | ack done; wait for the arbiter to release stb before accepting again
module wb_ram_slave #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic          clk,
    input  logic          rst,
    wb_ram_slave_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT, ACK, HOLD} state_t;

    state_t            state, state_nxt;
    logic [3:0]        cnt, cnt_nxt;
    logic              latch, enter_ack;

    logic [ADDR_W-1:0] idx_q;
    logic              we_q, rng_q;
    logic [DATA_W-1:0] dat_q;
    logic              ack_q;
    logic [DATA_W-1:0] dat_o_q;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    logic              req;
    logic              in_range;
    logic [ADDR_W-1:0] idx_eff;
    logic              we_eff, rng_eff;
    logic [DATA_W-1:0] dat_eff;
    logic              mem_we, rd_en;

    assign req      = bus.wb_cyc & bus.wb_stb;
    assign in_range = (bus.wb_adr[DATA_W-1:ADDR_W] == '0);

    // With zero wait states ACK is entered straight from IDLE, before the latches hold the request.
    assign idx_eff = (state == IDLE) ? bus.wb_adr[ADDR_W-1:0] : idx_q;
    assign we_eff  = (state == IDLE) ? bus.wb_we              : we_q;
    assign dat_eff = (state == IDLE) ? bus.wb_dat_i           : dat_q;
    assign rng_eff = (state == IDLE) ? in_range               : rng_q;

    assign mem_we = enter_ack &  we_eff & rng_eff;
    assign rd_en  = enter_ack & ~we_eff & rng_eff;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        latch     = 1'b0;
        enter_ack = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    latch   = 1'b1;
                    cnt_nxt = 4'(WAIT_CYCLES);
                    if (WAIT_CYCLES == 0) begin
                        state_nxt = ACK;
                        enter_ack = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!req) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 4'd0;
                end else if (cnt == 4'd1) begin
                    state_nxt = ACK;
                    enter_ack = 1'b1;
                    cnt_nxt   = 4'd0;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            ACK:     state_nxt = HOLD;
            HOLD:    if (!req) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            rng_q   <= 1'b0;
            dat_q   <= '0;
            ack_q   <= 1'b0;
            dat_o_q <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (latch) begin
                idx_q <= bus.wb_adr[ADDR_W-1:0];
                we_q  <= bus.wb_we;
                rng_q <= in_range;
                dat_q <= bus.wb_dat_i;
            end
`ifdef WB_ERR_EN
            ack_q   <= enter_ack & rng_eff;
`else
            ack_q   <= enter_ack;
`endif
            dat_o_q <= rd_en ? mem[idx_eff] : '0;
        end
    end

    // RAM contents survive reset; rst forces IDLE so no write can start while it is held.
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[idx_eff] <= dat_eff;
    end

`ifdef WB_ERR_EN
    logic err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_q <= 1'b0;
        else
            err_q <= enter_ack & ~rng_eff;
    end

    assign bus.wb_err = err_q;
`endif

    assign bus.wb_ack   = ack_q;
    assign bus.wb_dat_o = dat_o_q;
endmodule

// File: tb/tb_wb_ram_slave.sv
// Directed bench for wb_ram_slave: three instances with 0, 1 and 3 wait states.
// Table-driven transfers plus hand sequences for held stb, aborted request, reset and alternation.
module tb_wb_ram_slave;
`ifdef WB_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [2:0]       cyc, stb, we;
    logic [2:0][31:0] adr, wdat;
    logic [2:0]       ack, err;
    logic [2:0][31:0] dout;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        wb_ram_slave_if #(.DATA_W(32)) bus ();
        assign bus.wb_cyc   = cyc[g];
        assign bus.wb_stb   = stb[g];
        assign bus.wb_we    = we[g];
        assign bus.wb_adr   = adr[g];
        assign bus.wb_dat_i = wdat[g];
        assign ack[g]       = bus.wb_ack;
        assign dout[g]      = bus.wb_dat_o;
`ifdef WB_ERR_EN
        assign err[g]       = bus.wb_err;
`else
        assign err[g]       = 1'b0;
`endif
        wb_ram_slave #(
            .DATA_W(32),
            .ADDR_W(10),
            .WAIT_CYCLES(g == 0 ? 0 : (g == 1 ? 1 : 3))
        ) dut (
            .clk(clk),
            .rst(rst),
            .bus(bus.slave)
        );
    end

    int errors = 0;
    int checks = 0;

    function automatic int wc(input int d);
        return (d == 0) ? 0 : ((d == 1) ? 1 : 3);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Arbiter-style transfer: raise at a negedge, wait for the response, keep stb one more cycle, drop.
    task automatic xfer(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                        input logic oor, input logic [31:0] exp_rd, input string name,
                        output longint t_resp);
        int   k;
        logic seen, stray;
        cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; wdat[d] = wd;
        seen = 1'b0; stray = 1'b0; k = 0; t_resp = 0;
        while (!seen && k <= 20) begin
            @(negedge clk);
            if (ack[d] || err[d]) begin
                seen   = 1'b1;
                t_resp = $time;
            end else begin
                if (dout[d] != 32'h0) stray = 1'b1;
                k++;
                we[d]   = ~w;
                wdat[d] = ~wd;
            end
        end
        if (!seen) begin
            chk({name, " timeout"}, 32'(k), 32'(wc(d)));
        end else begin
            chk({name, " latency"}, 32'(k), 32'(wc(d)));
            chk({name, " ack/err"}, {30'h0, ack[d], err[d]},
                {30'h0, !(ERR_EN && oor), ERR_EN && oor});
            chk({name, " dat_o"}, dout[d], exp_rd);
        end
        chk({name, " dat_o idle"}, {31'h0, stray}, 32'h0);
        @(negedge clk);
        chk({name, " single-cycle"}, {30'h0, ack[d], err[d]}, 32'h0);
        cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
        @(negedge clk);
    endtask

    typedef struct {
        int          d;
        logic        w;
        logic [31:0] a;
        logic [31:0] wd;
        logic        oor;
        logic [31:0] rd;
    } vec_t;

    vec_t   vec [16];
    longint t0, t1;
    int     n;

    initial begin
        vec[0]  = '{1, 1'b1, 32'h0000_0005, 32'hDEAD_BEEF, 1'b0, 32'h0};
        vec[1]  = '{1, 1'b0, 32'h0000_0005, 32'h0,         1'b0, 32'hDEAD_BEEF};
        vec[2]  = '{1, 1'b1, 32'h0000_0000, 32'hA5A5_A5A5, 1'b0, 32'h0};
        vec[3]  = '{1, 1'b0, 32'h0000_0400, 32'h0,         1'b1, 32'h0};
        vec[4]  = '{1, 1'b1, 32'h0000_0400, 32'hFFFF_FFFF, 1'b1, 32'h0};
        vec[5]  = '{1, 1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'hA5A5_A5A5};
        vec[6]  = '{1, 1'b1, 32'h0000_03FF, 32'h1357_9BDF, 1'b0, 32'h0};
        vec[7]  = '{1, 1'b0, 32'h0000_03FF, 32'h0,         1'b0, 32'h1357_9BDF};
        vec[8]  = '{1, 1'b0, 32'h8000_0000, 32'h0,         1'b1, 32'h0};
        vec[9]  = '{0, 1'b1, 32'h0000_0010, 32'h1111_2222, 1'b0, 32'h0};
        vec[10] = '{0, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'h1111_2222};
        vec[11] = '{2, 1'b1, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'h0};
        vec[12] = '{2, 1'b1, 32'h0000_0020, 32'hCAFE_F00D, 1'b0, 32'h0};
        vec[13] = '{2, 1'b0, 32'h0000_0020, 32'h0,         1'b0, 32'hCAFE_F00D};
        vec[14] = '{0, 1'b1, 32'h0000_03FF, 32'h0F0F_0F0F, 1'b0, 32'h0};
        vec[15] = '{0, 1'b0, 32'h0000_03FF, 32'h0,         1'b0, 32'h0F0F_0F0F};

        rst = 1'b1;
        cyc = '0; stb = '0; we = '0; adr = '0; wdat = '0;
        @(negedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++)
            chk($sformatf("reset dut%0d", d), {ack[d] | err[d], dout[d][30:0]}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 16; i++)
            xfer(vec[i].d, vec[i].w, vec[i].a, vec[i].wd, vec[i].oor, vec[i].rd,
                 $sformatf("vec%0d", i), t0);

        // Lingering stb with zero wait states: one ack, then HOLD until stb drops.
        cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; adr[0] = 32'h44; wdat[0] = 32'h55;
        @(negedge clk);
        chk("hold first ack", {31'h0, ack[0]}, 32'h1);
        n = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ack[0]) n++;
        end
        chk("hold extra acks", 32'(n), 32'h0);
        cyc[0] = 1'b0; stb[0] = 1'b0; we[0] = 1'b0;
        @(negedge clk);
        xfer(0, 1'b0, 32'h44, 32'h0, 1'b0, 32'h55, "hold readback", t0);

        // Request dropped in the second wait cycle: no ack, no write.
        cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; adr[2] = 32'h10; wdat[2] = 32'hBADB_AD00;
        @(negedge clk);
        @(negedge clk);
        cyc[2] = 1'b0;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ack[2]) n++;
        end
        chk("abort acks", 32'(n), 32'h0);
        stb[2] = 1'b0; we[2] = 1'b0;
        @(negedge clk);
        xfer(2, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0, "abort readback", t0);

        // Reset in WAIT aborts the write.
        cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; adr[2] = 32'h20; wdat[2] = 32'h1234_5678;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst ack", {31'h0, ack[2]}, 32'h0);
        n = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ack[2] || dout[2] != 32'h0) n++;
        end
        chk("rst quiet", 32'(n), 32'h0);
        cyc[2] = 1'b0; stb[2] = 1'b0; we[2] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        xfer(2, 1'b0, 32'h20, 32'h0, 1'b0, 32'hCAFE_F00D, "rst readback", t0);

        // Two CPUs alternating with a one-cycle stb gap.
        xfer(1, 1'b1, 32'h1, 32'h1, 1'b0, 32'h0, "alt cpu0 wr", t0);
        xfer(1, 1'b0, 32'h1, 32'h0, 1'b0, 32'h1, "alt cpu1 rd", t1);
        chk("alt ack spacing", 32'((t1 - t0) / 10), 32'(wc(1) + 3));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
